// File: rtl/split_into_a_and_b_using_fifos.sv
// Purpose: split packed {b, a} upstream words into two independently drained FIFO-buffered streams.
// Latency: a word accepted at a rising edge is visible on both outputs after that edge (1 cycle, no fall-through).
// Backpressure: upstream stalls whenever either FIFO is full; up_ready depends only on registered counts.
module split_into_a_and_b_using_fifos #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [2*width-1:0] up_data,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [width-1:0]   a_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [width-1:0]   b_data
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);
  localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

  // Storage is deliberately left unreset; only pointers and counts define validity.
  logic [width-1:0] a_mem_q [depth];
  logic [width-1:0] b_mem_q [depth];

  logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PW-1:0] b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  logic push;
  logic a_pop;
  logic b_pop;

  // Pointers wrap explicitly at depth-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Upstream is accepted only when both halves have room, so a word is never split.
  assign up_ready = rst_n & (a_cnt_q != CNT_FULL) & (b_cnt_q != CNT_FULL);
  assign push     = up_valid & up_ready;

  assign a_valid = (a_cnt_q != '0);
  assign b_valid = (b_cnt_q != '0);
  assign a_pop   = a_valid & a_ready;
  assign b_pop   = b_valid & b_ready;
  assign a_data  = a_mem_q[a_rd_q];
  assign b_data  = b_mem_q[b_rd_q];

  // Next-state for both FIFOs; the two read sides never interact.
  always_comb begin
    a_wr_d  = a_wr_q;
    a_rd_d  = a_rd_q;
    a_cnt_d = a_cnt_q;
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    b_cnt_d = b_cnt_q;

    if (push) begin
      a_wr_d = ptr_inc(a_wr_q);
      b_wr_d = ptr_inc(b_wr_q);
    end
    if (a_pop) a_rd_d = ptr_inc(a_rd_q);
    if (b_pop) b_rd_d = ptr_inc(b_rd_q);

    case ({push, a_pop})
      2'b10:   a_cnt_d = a_cnt_q + 1'b1;
      2'b01:   a_cnt_d = a_cnt_q - 1'b1;
      default: a_cnt_d = a_cnt_q;
    endcase

    case ({push, b_pop})
      2'b10:   b_cnt_d = b_cnt_q + 1'b1;
      2'b01:   b_cnt_d = b_cnt_q - 1'b1;
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  // Control state register; async reset empties both FIFOs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_cnt_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      a_cnt_q <= a_cnt_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  // Write both halves of an accepted word into their FIFOs at the current write pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem_q[a_wr_q] <= up_data[width-1:0];
      b_mem_q[b_wr_q] <= up_data[2*width-1:width];
    end
  end

endmodule

// File: tb/tb_split_into_a_and_b_using_fifos.sv
// Purpose: directed bench for the a/b stream splitter with a queue-based scoreboard.
// Latency: checks 1-cycle visibility of accepted words and full/empty boundary timing.
// Backpressure: exercises one-side-full stall, simultaneous push/pop and random consumer readies.
module tb_split_into_a_and_b_using_fifos;

  localparam int W = 8;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           up_valid;
  logic           up_ready;
  logic [2*W-1:0] up_data;
  logic           a_valid;
  logic           a_ready;
  logic [W-1:0]   a_data;
  logic           b_valid;
  logic           b_ready;
  logic [W-1:0]   b_data;

  int n_assert = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  split_into_a_and_b_using_fifos #(.width(W), .depth(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard update from the handshakes about to happen, then advance one cycle.
  task automatic step();
    logic [W-1:0] e;
    if (up_valid && up_ready) begin
      qa.push_back(up_data[W-1:0]);
      qb.push_back(up_data[2*W-1:W]);
      n_push++;
      if (dut.a_wr_q == 2'd3) wr_wraps++;
    end
    if (a_valid && a_ready) begin
      chk("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_data", 32'(a_data), 32'(e));
      end
      if (dut.a_rd_q == 2'd3) rd_wraps++;
    end
    if (b_valid && b_ready) begin
      chk("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_data", 32'(b_data), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int acc;
    rst_n    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_up_ready", 32'(up_ready), 32'd1);
    @(negedge clk);

    // Basic split with 1-cycle latency
    a_ready = 1'b1; b_ready = 1'b1;
    up_valid = 1'b1; up_data = 16'h0201;
    chk("basic_a_valid_before", 32'(a_valid), 32'd0);
    step();
    chk("basic_a_valid_after", 32'(a_valid), 32'd1);
    chk("basic_b_valid_after", 32'(b_valid), 32'd1);
    chk("basic_a_first", 32'(a_data), 32'h01);
    chk("basic_b_first", 32'(b_data), 32'h02);
    up_data = 16'h0403;
    step();
    chk("basic_a_second", 32'(a_data), 32'h03);
    chk("basic_b_second", 32'(b_data), 32'h04);
    up_valid = 1'b0;
    step();
    chk("basic_a_empty", 32'(a_valid), 32'd0);
    chk("basic_b_empty", 32'(b_valid), 32'd0);

    // Full via b side only
    a_ready = 1'b1; b_ready = 1'b0;
    acc = n_push;
    for (int i = 0; i < 6; i++) begin
      up_valid = 1'b1;
      up_data  = 16'(16'h2000 + 16'(i * 16'h0101));
      chk($sformatf("full_up_ready_%0d", i), 32'(up_ready), (i < D) ? 32'd1 : 32'd0);
      step();
    end
    up_valid = 1'b0;
    chk("full_accepted", 32'(n_push - acc), 32'd4);
    step();
    chk("full_a_drained", 32'(a_valid), 32'd0);
    chk("full_b_count", 32'(dut.b_cnt_q), 32'd4);
    chk("full_up_ready_held", 32'(up_ready), 32'd0);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    chk("full_up_ready_restored", 32'(up_ready), 32'd1);
    b_ready = 1'b1;
    repeat (3) step();
    chk("full_b_drained", 32'(b_valid), 32'd0);

    // Simultaneous push/pop at count 2
    a_ready = 1'b0; b_ready = 1'b0;
    up_valid = 1'b1; up_data = 16'h3130; step();
    up_data = 16'h3332; step();
    chk("pp_a_count_pre", 32'(dut.a_cnt_q), 32'd2);
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      up_data = 16'(16'h3534 + 16'(i * 16'h0202));
      step();
      chk($sformatf("pp_a_count_%0d", i), 32'(dut.a_cnt_q), 32'd2);
      chk($sformatf("pp_b_count_%0d", i), 32'(dut.b_cnt_q), 32'd2);
    end
    up_valid = 1'b0;
    repeat (2) step();
    chk("pp_drained", 32'(a_valid | b_valid), 32'd0);

    // Wrap-around with random independent readies
    wr_wraps = 0; rd_wraps = 0;
    acc = 0; cyc = 0;
    while ((acc < 10 || qa.size() != 0 || qb.size() != 0) && cyc < 400) begin
      up_valid = (acc < 10);
      up_data  = 16'(16'h1000 + acc);
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      if (up_valid && up_ready) acc++;
      step();
      cyc++;
    end
    up_valid = 1'b0;
    chk("wrap_done_in_budget", 32'(cyc < 400), 32'd1);
    chk("wrap_accepted", 32'(acc), 32'd10);
    chk("wrap_wr_wraps", 32'(wr_wraps >= 2), 32'd1);
    chk("wrap_rd_wraps", 32'(rd_wraps >= 2), 32'd1);

    // Empty pop has no effect
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("empty_a_valid_%0d", i), 32'(a_valid), 32'd0);
      chk($sformatf("empty_a_count_%0d", i), 32'(dut.a_cnt_q), 32'd0);
    end

    // Reset mid-stream with 3 words buffered
    a_ready = 1'b0; b_ready = 1'b0;
    up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_data = 16'(16'h4140 + 16'(i * 16'h0202));
      step();
    end
    up_valid = 1'b0;
    chk("mid_a_count", 32'(dut.a_cnt_q), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 32'(a_valid), 32'd0);
    chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
    chk("mid_rst_up_ready", 32'(up_ready), 32'd0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_post_up_ready", 32'(up_ready), 32'd1);
    a_ready = 1'b1; b_ready = 1'b1;
    up_valid = 1'b1; up_data = 16'h0605;
    step();
    up_valid = 1'b0;
    chk("mid_first_a", 32'(a_data), 32'h05);
    chk("mid_first_b", 32'(b_data), 32'h06);
    step();
    chk("mid_drained", 32'(a_valid | b_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/split_into_a_and_b_using_fifos.md
# split_into_a_and_b_using_fifos

Stream splitter that reverses the a + b join direction: one upstream valid/ready stream carries packed operand pairs {b, a}. The block distributes the halves into two independent downstream streams, a and b, each buffered by its own internal FIFO. It sits where a single producer feeds two consumers that drain at different rates. An upstream word is accepted atomically: both halves are written, or neither is.

## Interface
- width — default 8 — width of each output operand; upstream word is 2*width.
- depth — default 10 — entries per internal FIFO; any integer ≥ 2, not restricted to powers of two.

- clk  in  1  — single clock; all state updates on rising edge.
- rst_n  in  1  — reset, asynchronous and active-low.
- up_valid  in  1  — upstream word present.
- up_ready  out  1  — block can accept the upstream word this cycle.
- up_data  in  2*width  — [width-1:0] = a, [2*width-1:width] = b.
- a_valid  out  1  — a FIFO non-empty.
- a_ready  in  1  — a consumer pops.
- a_data  out  width  — head of a FIFO.
- b_valid  out  1  — b FIFO non-empty.
- b_ready  in  1  — b consumer pops.
- b_data  out  width  — head of b FIFO.

## Operation
- Two internal FIFOs, a and b. Each FIFO has:
  - storage of depth × width;
  - write and read pointers of $clog2(depth) bits, each wrapping from depth-1 to 0;
  - an occupancy counter of $clog2(depth+1) bits.
- The FIFOs are internal to this block; the shared valid/ready FIFO wrapper is not instantiated because its reset is synchronous active-high.
- up_ready = rst_n & (a_count != depth) & (b_count != depth).
  - Purely registered-state based; no combinational path from a_ready/b_ready to up_ready.
- push = up_valid & up_ready. On push, a half goes to a_mem[a_wr_ptr] and b half to b_mem[b_wr_ptr]; both write pointers advance.
- a_valid = (a_count != 0); a_data = a_mem[a_rd_ptr]. The b side is identical.
- a_pop = a_valid & a_ready advances a_rd_ptr. The b side is identical and fully independent of a.
- Counter update per FIFO:
  - push only: +1;
  - pop only: −1;
  - push and pop together: unchanged;
  - neither: unchanged.
- Popping an empty FIFO (ready while valid=0) has no effect.
- Data ordering is preserved per side. The k-th a word out and the k-th b word out both come from the k-th accepted upstream word.
- Back-pressure: if either FIFO is full, the whole upstream stalls, even when the other FIFO has space.
  - A pop on the full FIFO frees space from the next cycle only; up_ready rises one cycle after that pop.
- Memory contents are not reset. Pointers, counters and all valids are reset.

## Timing
- While rst_n = 0, asynchronously: pointers = 0, counts = 0, a_valid = 0, b_valid = 0, up_ready = 0. a_data and b_data are don't-care.
- First cycle after rst_n deasserts: up_ready = 1.
- Latency: a word accepted at edge N is visible with a_valid = b_valid = 1 after edge N. This is 1 cycle, and no fall-through in the same cycle.
- Throughput: 1 word/cycle sustained when both consumers keep ready = 1.
- Full boundary: after depth accepts with no pops, up_ready = 0. A pop at edge M restores up_ready after edge M.
- Empty boundary: after the last pop, valid drops after that edge. A same-cycle push keeps valid high.
- Pointer wrap is exercised at depth-1 → 0 for non-power-of-two depth.
- Reset asserted mid-operation discards all buffered words immediately, with no further handshakes completing.

## Test plan
Parameters for all scenarios: width = 8, depth = 4.

- **Basic split:** push 0x0201, then 0x0403, with both readies = 1.
  - a stream yields 0x01, 0x03; b stream yields 0x02, 0x04.
  - Each appears 1 cycle after its accept.
- **Full via one side:** b_ready = 0, a_ready = 1, push 6 words back-to-back.
  - Exactly 4 words are accepted; up_ready = 0 from the 5th cycle on.
  - a drains all 4; b_count = 4.
  - Raise b_ready for one cycle: up_ready = 1 on the next cycle.
- **Simultaneous push/pop at count = 2:** counts stay 2 and ordering is intact.
- **Wrap-around:** push and pop 10 words 0x1000+i with random independent readies.
  - Sequences are i-ordered on both sides.
  - Pointers wrap 3 → 0 at least twice.
- **Empty pop:** a_ready = 1 with a FIFO empty for 5 cycles.
  - a_valid stays 0; count stays 0.
- **Reset mid-stream:** with 3 words buffered, pull rst_n low for 1 cycle.
  - Valids drop immediately and up_ready = 0 during reset.
  - After release, up_ready = 1 and the next push is the first word out.
